vslc_eval_stack: RTL and testbench

Parametrised evaluation stack for the VSLC core, generalising the fixed 16-entry single-bit logic stack to configurable depth and entry width. It executes one stack opcode per cycle (push, pop, dup, swap, bitwise AND/OR/XOR/NOT, clear) and exposes top-of-stack, next-on-stack and occupancy to the executor. It sits between the instruction decoder and the output latch logic inside the core's exec stage.

---
 rtl/vslc_eval_stack.sv | 143 ++++++++++++++
 tb/tb_vslc_eval_stack.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vslc_eval_stack.sv
// vslc_eval_stack: parametrised shift-register evaluation stack for the exec stage.
// Define VSLC_STACK_ERR_EN to suppress illegal ops and raise sticky ovf/udf flags.
module vslc_eval_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_POP  = 4'd2;
    localparam logic [3:0] OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_CLR  = 4'd9;

    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             has1, room, blk;
    logic [WIDTH-1:0] bin_v;
`ifdef VSLC_STACK_ERR_EN
    logic             short_s, over_s;
`endif

    assign has1 = (cnt_q != '0);
    assign room = (cnt_q != CNT_MAX);

    always_comb begin
        bin_v = stk_q[0] & stk_q[1];
        if (op == OP_OR)  bin_v = stk_q[0] | stk_q[1];
        if (op == OP_XOR) bin_v = stk_q[0] ^ stk_q[1];
    end

`ifdef VSLC_STACK_ERR_EN
    always_comb begin
        short_s = 1'b0;
        over_s  = 1'b0;
        case (op)
            OP_PUSH: over_s = !room;
            OP_POP,
            OP_NOT:  short_s = !has1;
            // DUP on an empty stack is an underflow only
            OP_DUP: begin
                short_s = !has1;
                over_s  = has1 && !room;
            end
            OP_SWAP,
            OP_AND,
            OP_OR,
            OP_XOR:  short_s = (cnt_q < CW'(2));
            default: ;
        endcase
        blk = op_valid && (short_s || over_s);
    end
`else
    assign blk = 1'b0;
`endif

    always_comb begin
        stk_d = stk_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
`ifdef VSLC_STACK_ERR_EN
        if (op_valid && short_s) udf_d = 1'b1;
        if (op_valid && over_s)  ovf_d = 1'b1;
`endif
        if (op_valid && !blk) begin
            case (op)
                OP_PUSH,
                OP_DUP: begin
                    for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
                    stk_d[0] = (op == OP_DUP) ? stk_q[0] : din;
                    cnt_d = room ? cnt_q + CW'(1) : cnt_q;
                end
                OP_POP,
                OP_AND,
                OP_OR,
                OP_XOR: begin
                    for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                    stk_d[DEPTH-1] = '0;
                    if (op != OP_POP) stk_d[0] = bin_v;
                    cnt_d = has1 ? cnt_q - CW'(1) : '0;
                end
                OP_SWAP: begin
                    stk_d[0] = stk_q[1];
                    stk_d[1] = stk_q[0];
                end
                OP_NOT: stk_d[0] = ~stk_q[0];
                OP_CLR: begin
                    for (int i = 0; i < DEPTH; i++) stk_d[i] = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    udf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            stk_q <= stk_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign tos   = stk_q[0];
    assign nos   = stk_q[1];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_MAX);
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_vslc_eval_stack.sv
// Directed bench for vslc_eval_stack (DEPTH=4, WIDTH=8), both error-mode builds.
module tb_vslc_eval_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [3:0] op;
    logic [7:0] din;
    logic [7:0] tos, nos;
    logic [2:0] count;
    logic       empty, full, ovf, udf;

    int n_chk = 0;
    int n_err = 0;

    vslc_eval_stack #(.DEPTH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .din(din),
        .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] o, input logic [7:0] d);
        @(negedge clk);
        op_valid = 1'b1;
        op = o;
        din = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".tos"}, tos, 0);
        chk({tag, ".nos"}, nos, 0);
        chk({tag, ".count"}, count, 0);
        chk({tag, ".empty"}, empty, 1);
        chk({tag, ".full"}, full, 0);
        chk({tag, ".ovf"}, ovf, 0);
        chk({tag, ".udf"}, udf, 0);
    endtask

    initial begin
        rst = 1'b1;
        op_valid = 1'b0;
        op = 4'd0;
        din = 8'd0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b0;

        // logic sequence
        step(4'd1, 8'd1);
        step(4'd1, 8'd0);
        step(4'd1, 8'd1);
        chk("p3.tos", tos, 1);
        chk("p3.nos", nos, 0);
        chk("p3.count", count, 3);
        step(4'd5, 8'd0);
        chk("and.tos", tos, 0);
        chk("and.nos", nos, 1);
        chk("and.count", count, 2);
        step(4'd6, 8'd0);
        chk("or.tos", tos, 1);
        chk("or.count", count, 1);

        // byte-wide ops
        step(4'd9, 8'd0);
        chk("clr.count", count, 0);
        step(4'd1, 8'hA5);
        step(4'd1, 8'h0F);
        step(4'd7, 8'd0);
        chk("xor.tos", tos, 8'hAA);
        chk("xor.count", count, 1);
        step(4'd8, 8'd0);
        chk("not.tos", tos, 8'h55);
        chk("not.count", count, 1);
        step(4'd3, 8'd0);
        step(4'd4, 8'd0);
        chk("swap.tos", tos, 8'h55);
        chk("swap.nos", nos, 8'h55);
        chk("swap.count", count, 2);

        // overflow
        step(4'd9, 8'd0);
        for (int i = 1; i <= 5; i++) step(4'd1, 8'(i));
        chk("ovf.count", count, 4);
        chk("ovf.full", full, 1);
`ifdef VSLC_STACK_ERR_EN
        chk("ovf.tos", tos, 4);
        chk("ovf.ovf", ovf, 1);
`else
        chk("ovf.tos", tos, 5);
        chk("ovf.ovf", ovf, 0);
`endif
        chk("ovf.udf", udf, 0);
        for (int i = 0; i < 3; i++) step(4'd2, 8'd0);
`ifdef VSLC_STACK_ERR_EN
        chk("ovf.bottom", tos, 1);
`else
        chk("ovf.bottom", tos, 2);
`endif
        chk("ovf.pcount", count, 1);
        chk("ovf.pfull", full, 0);

        // underflow
        step(4'd9, 8'd0);
        chk("clr.ovf", ovf, 0);
        step(4'd5, 8'd0);
        chk("udf.count", count, 0);
        chk("udf.tos", tos, 0);
`ifdef VSLC_STACK_ERR_EN
        chk("udf.udf", udf, 1);
`else
        chk("udf.udf", udf, 0);
`endif
        step(4'd9, 8'd0);
        chk("clr.udf", udf, 0);
        step(4'd1, 8'd1);
        step(4'd5, 8'd0);
`ifdef VSLC_STACK_ERR_EN
        chk("udf1.tos", tos, 1);
        chk("udf1.count", count, 1);
        chk("udf1.udf", udf, 1);
`else
        chk("udf1.tos", tos, 0);
        chk("udf1.count", count, 0);
        chk("udf1.udf", udf, 0);
`endif

        // idle / undefined op
        step(4'd9, 8'd0);
        step(4'd1, 8'd7);
        @(negedge clk);
        op = 4'd1;
        din = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle.tos", tos, 7);
        chk("idle.count", count, 1);
        step(4'd15, 8'd3);
        chk("nop15.tos", tos, 7);
        chk("nop15.nos", nos, 0);
        chk("nop15.count", count, 1);

        // async reset mid-POP
        step(4'd1, 8'd1);
        step(4'd1, 8'd1);
        chk("pre.count", count, 3);
        @(negedge clk);
        op_valid = 1'b1;
        op = 4'd2;
        #2;
        rst = 1'b1;
        #1;
        chk_reset("arst");
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(4'd1, 8'd9);
        chk("post.tos", tos, 9);
        chk("post.nos", nos, 0);
        chk("post.count", count, 1);
        chk("post.empty", empty, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
